// File: rtl/cpu_ctrl_fsm_g2.sv
// Multicycle control FSM for the 16-bit CPU: opcode decode, datapath enables, memory ready/timeout, resumable halt.
// Optional macro CTRL_INSTR_CNT_EN adds the instr_count retired-fetch counter output.
module cpu_ctrl_fsm_g2 #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              mem_ready,
    input  logic              resume,
    output logic              imm_sel,
    output logic              pc_addr_sel,
    output logic              ld_sel,
    output logic              jmp_sel,
    output logic              wsel_mem,
    output logic              sw_sel,
    output logic              flag_en,
    output logic              pc_en,
    output logic              reg_wen,
    output logic              mem_we,
    output logic              mem_req,
    output logic              fault,
`ifdef CTRL_INSTR_CNT_EN
    output logic [CNT_W-1:0]  instr_count,
`endif
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_R_REG    = 4'd2,
        S_LD_REQ   = 4'd3,
        S_LD_WB    = 4'd4,
        S_ST_REQ   = 4'd5,
        S_ST_DONE  = 4'd6,
        S_JMP      = 4'd7,
        S_JMP_DONE = 4'd8,
        S_HALT     = 4'd9,
        S_R_IMM    = 4'd10,
        S_WB       = 4'd11,
        S_JAL      = 4'd12,
        S_JAL_DONE = 4'd13,
        S_FAULT    = 4'd14,
        S_SPECIAL  = 4'd15
    } state_t;

    localparam int WAIT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WAIT_TMO = WAIT_W'(TIMEOUT_CYC);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [3:0]        opcode;
    logic              timed_out;
    logic              instr_unused;

    assign opcode       = instr[DATA_W-1 -: 4];
    assign instr_unused = ^instr[DATA_W-5:0];
    assign timed_out    = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_TMO);
    assign state        = cur_state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_state <= S_RESET;
            wait_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
        end
    end

    // Next state and wait counter; counter only moves while held in a request state.
    always_comb begin
        nxt_state = S_RESET;
        wait_nxt  = '0;
        case (cur_state)
            S_RESET: nxt_state = S_FETCH;
            S_FETCH: begin
                case (opcode)
                    4'b0000: nxt_state = S_R_REG;
                    4'b0001: nxt_state = S_LD_REQ;
                    4'b0010: nxt_state = S_ST_REQ;
                    4'b0011: nxt_state = S_JMP;
                    4'b0100: nxt_state = S_HALT;
                    4'b1000: nxt_state = S_RESET;
                    4'b1100: nxt_state = S_JAL;
                    4'b1111: nxt_state = S_SPECIAL;
                    default: nxt_state = S_R_IMM;
                endcase
            end
            S_R_REG, S_R_IMM: nxt_state = S_WB;
            S_WB, S_LD_WB, S_ST_DONE, S_JMP_DONE, S_JAL_DONE: nxt_state = S_FETCH;
            S_LD_REQ, S_ST_REQ: begin
                if (mem_ready) begin
                    nxt_state = (cur_state == S_LD_REQ) ? S_LD_WB : S_ST_DONE;
                end else if (timed_out) begin
                    nxt_state = S_FAULT;
                end else begin
                    nxt_state = cur_state;
                    wait_nxt  = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
                end
            end
            S_SPECIAL: nxt_state = S_ST_DONE;
            S_JMP:     nxt_state = S_JMP_DONE;
            S_JAL:     nxt_state = S_JAL_DONE;
            S_HALT:    nxt_state = resume ? S_FETCH : S_HALT;
            S_FAULT:   nxt_state = S_FAULT;
            default:   nxt_state = S_RESET;
        endcase
    end

    // Moore decode; pc_en is Mealy only in the request states and HALT.
    always_comb begin
        imm_sel     = 1'b0;
        pc_addr_sel = 1'b0;
        ld_sel      = 1'b0;
        jmp_sel     = 1'b0;
        wsel_mem    = 1'b0;
        sw_sel      = 1'b1;
        flag_en     = 1'b0;
        pc_en       = 1'b0;
        reg_wen     = 1'b0;
        mem_we      = 1'b0;
        mem_req     = 1'b0;
        fault       = 1'b0;
        case (cur_state)
            S_FETCH, S_WB, S_ST_DONE, S_JMP_DONE, S_JAL_DONE: pc_addr_sel = 1'b1;
            S_R_REG, S_R_IMM: begin
                imm_sel     = (cur_state == S_R_IMM);
                pc_addr_sel = 1'b1;
                flag_en     = 1'b1;
                pc_en       = 1'b1;
                reg_wen     = 1'b1;
            end
            S_LD_REQ: begin
                ld_sel  = 1'b1;
                mem_req = 1'b1;
                pc_en   = mem_ready;
            end
            S_LD_WB: begin
                pc_addr_sel = 1'b1;
                ld_sel      = 1'b1;
                reg_wen     = 1'b1;
                wsel_mem    = 1'b1;
            end
            S_ST_REQ: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                pc_en   = mem_ready;
            end
            S_SPECIAL: begin
                mem_we = 1'b1;
                pc_en  = 1'b1;
            end
            S_JMP, S_JAL: begin
                pc_addr_sel = 1'b1;
                jmp_sel     = 1'b1;
                pc_en       = 1'b1;
                reg_wen     = (cur_state == S_JAL);
            end
            S_HALT: begin
                pc_addr_sel = 1'b1;
                pc_en       = resume;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_INSTR_CNT_EN
    // Counts fetches that issue a real instruction; the 1000 no-op is excluded.
    always_ff @(posedge clock) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (cur_state == S_FETCH && opcode != 4'b1000) begin
            instr_count <= instr_count + 1'b1;
        end
    end
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm_g2.sv
// Directed bench for cpu_ctrl_fsm_g2: state codes and packed output vector checked after each edge.
module tb_cpu_ctrl_fsm_g2;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        mem_ready;
    logic        resume;
    logic imm_sel, pc_addr_sel, ld_sel, jmp_sel, wsel_mem, sw_sel;
    logic flag_en, pc_en, reg_wen, mem_we, mem_req, fault;
    logic [3:0]  state;
`ifdef CTRL_INSTR_CNT_EN
    logic [15:0] instr_count;
    logic [15:0] cnt_before;
`endif

    int checks   = 0;
    int failures = 0;

    // {imm,pc_addr,ld,jmp,wsel_mem,sw,flag,pc_en,reg_wen,mem_we,mem_req,fault}
    logic [11:0] ov;
    assign ov = {imm_sel, pc_addr_sel, ld_sel, jmp_sel, wsel_mem, sw_sel,
                 flag_en, pc_en, reg_wen, mem_we, mem_req, fault};

    cpu_ctrl_fsm_g2 #(.DATA_W(16), .TIMEOUT_CYC(15), .CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .mem_ready   (mem_ready),
        .resume      (resume),
        .imm_sel     (imm_sel),
        .pc_addr_sel (pc_addr_sel),
        .ld_sel      (ld_sel),
        .jmp_sel     (jmp_sel),
        .wsel_mem    (wsel_mem),
        .sw_sel      (sw_sel),
        .flag_en     (flag_en),
        .pc_en       (pc_en),
        .reg_wen     (reg_wen),
        .mem_we      (mem_we),
        .mem_req     (mem_req),
        .fault       (fault),
`ifdef CTRL_INSTR_CNT_EN
        .instr_count (instr_count),
`endif
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Lets any input change made after the edge settle, then compares state and outputs.
    task automatic chk(input string tag, input logic [3:0] exp_st, input logic [11:0] exp_ov);
        #1;
        checks++;
        assert (state === exp_st) else begin
            failures++;
            $error("FAIL %s.state: observed=%0d expected=%0d", tag, state, exp_st);
        end
        checks++;
        assert (ov === exp_ov) else begin
            failures++;
            $error("FAIL %s.outs: observed=%03h expected=%03h", tag, ov, exp_ov);
        end
    endtask

    initial begin
        reset = 1'b0; instr = 16'h0123; mem_ready = 1'b0; resume = 1'b0;
        tick(); tick();
        chk("reset", 4'd0, 12'h040);
        reset = 1'b1;
        tick(); chk("rreg_fetch", 4'd1, 12'h440);
        tick(); chk("rreg", 4'd2, 12'h478);
        instr = 16'h1abc;
        tick(); chk("rreg_wb", 4'd11, 12'h440);
        tick(); chk("ld_fetch", 4'd1, 12'h440);
        // load with three wait cycles
        tick(); chk("ld_wait0", 4'd3, 12'h242);
        tick(); chk("ld_wait1", 4'd3, 12'h242);
        tick(); chk("ld_wait2", 4'd3, 12'h242);
        tick(); mem_ready = 1'b1; chk("ld_ready", 4'd3, 12'h252);
        instr = 16'h2def;
        tick(); mem_ready = 1'b0; chk("ld_wb", 4'd4, 12'h6C8);
        tick(); chk("st_fetch", 4'd1, 12'h440);
        // store that never completes: 16 cycles in ST_REQ then FAULT
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick(); else tick();
            chk($sformatf("st_wait%0d", i), 4'd5, 12'h046);
        end
        tick(); chk("fault", 4'd14, 12'h041);
        tick(); chk("fault_sticky", 4'd14, 12'h041);
        reset = 1'b0;
        tick(); chk("fault_clear", 4'd0, 12'h040);
        reset = 1'b1; instr = 16'h4000;
        tick(); chk("halt_fetch", 4'd1, 12'h440);
        tick(); chk("halt0", 4'd9, 12'h440);
        tick(); chk("halt1", 4'd9, 12'h440);
        resume = 1'b1; chk("halt_resume", 4'd9, 12'h450);
        instr = 16'hC123;
        tick(); resume = 1'b0; chk("jal_fetch", 4'd1, 12'h440);
`ifdef CTRL_INSTR_CNT_EN
        cnt_before = instr_count;
`endif
        tick(); instr = 16'h8000; chk("jal", 4'd12, 12'h558);
        tick(); chk("jal_done", 4'd13, 12'h440);
        tick(); chk("nop_fetch", 4'd1, 12'h440);
        tick(); chk("nop_reset", 4'd0, 12'h040);
`ifdef CTRL_INSTR_CNT_EN
        checks++;
        assert (instr_count === cnt_before + 16'd1) else begin
            failures++;
            $error("FAIL instr_count: observed=%0d expected=%0d", instr_count, cnt_before + 16'd1);
        end
`endif
        instr = 16'hF00D;
        tick(); chk("sp_fetch", 4'd1, 12'h440);
        tick(); instr = 16'h3000; chk("special", 4'd15, 12'h054);
        tick(); chk("sp_done", 4'd6, 12'h440);
        tick(); chk("jmp_fetch", 4'd1, 12'h440);
        tick(); instr = 16'h5a5a; chk("jmp", 4'd7, 12'h550);
        tick(); chk("jmp_done", 4'd8, 12'h440);
        tick(); chk("rimm_fetch", 4'd1, 12'h440);
        tick(); instr = 16'h2000; chk("rimm", 4'd10, 12'hC78);
        tick(); chk("rimm_wb", 4'd11, 12'h440);
        tick(); chk("st2_fetch", 4'd1, 12'h440);
        tick(); mem_ready = 1'b1; chk("st_ready", 4'd5, 12'h056);
        instr = 16'h1000;
        tick(); mem_ready = 1'b0; chk("st_done", 4'd6, 12'h440);
        tick(); chk("ld2_fetch", 4'd1, 12'h440);
        // ready on the same cycle the counter hits the timeout: ready wins
        tick(); chk("ld2_wait0", 4'd3, 12'h242);
        for (int i = 1; i < 16; i++) tick();
        chk("ld2_wait15", 4'd3, 12'h242);
        mem_ready = 1'b1; chk("ld2_ready_at_tmo", 4'd3, 12'h252);
        tick(); mem_ready = 1'b0; chk("ld2_wb", 4'd4, 12'h6C8);
        tick(); chk("ld3_fetch", 4'd1, 12'h440);
        tick(); chk("ld3_req", 4'd3, 12'h242);
        reset = 1'b0;
        tick(); chk("mid_access_reset", 4'd0, 12'h040);
        reset = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm_g2.md
Name: cpu_ctrl_fsm_g2

Overview:
Second-generation multicycle control FSM for the 16-bit CPU datapath. It decodes the opcode, sequences the PC, register-file, flag and memory-mux enables, and adds two things:
- a memory ready handshake with a wait/timeout counter, so load and store tolerate variable-latency memory;
- a resumable halt.

It sits between instruction memory output and the datapath mux/enable inputs. Data width and timeout are parametrised.

Parameters:
DATA_W, 16, instruction width; opcode = instr[DATA_W-1 -: 4]
TIMEOUT_CYC, 15, max wait cycles in a memory state before FAULT; 0 = no timeout
CNT_W, 16, width of the instr_count output (optional feature only)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
instr  in  DATA_W  current instruction word
mem_ready  in  1  memory completes the access this cycle
resume  in  1  leave HALT
imm_sel  out  1  ALU B operand = immediate
pc_addr_sel  out  1  memory address = PC
ld_sel  out  1  regfile write data = memory
jmp_sel  out  1  PC source = jump target
wsel_mem  out  1  regfile write-enable source = load path
sw_sel  out  1  switch input mux select
flag_en  out  1  latch ALU flags
pc_en  out  1  advance/load PC
reg_wen  out  1  regfile write
mem_we  out  1  data memory write
mem_req  out  1  memory access in progress
fault  out  1  memory timeout occurred (sticky)
state  out  4  current state code

Behaviour:
- Moore outputs are decoded from the state register. The only Mealy term is pc_en in LD_REQ, ST_REQ and HALT.
- When reset=0 at a clock edge, state goes to RESET, the wait counter clears and fault clears.

RESET (0):
- Outputs: sw_sel=1, all other outputs 0. These are the reset values of every output.
- Next state: FETCH.

FETCH (1):
- Outputs: pc_addr_sel=1, sw_sel=1.
- Decode of opcode op:
  - 0000 -> R_REG
  - 0001 -> LD_REQ
  - 0010 -> ST_REQ
  - 0011 -> JMP
  - 0100 -> HALT
  - 1000 -> RESET (no-op)
  - 1100 -> JAL
  - 1111 -> SPECIAL
  - any other value -> R_IMM

R_REG (2):
- Outputs: pc_addr_sel, flag_en, pc_en, reg_wen.
- Next state: WB.

R_IMM (10):
- Outputs: same as R_REG plus imm_sel.
- Next state: WB.

WB (11):
- Outputs: pc_addr_sel.
- Next state: FETCH.

LD_REQ (3):
- Outputs: ld_sel, mem_req, pc_en=mem_ready.
- Transitions:
  - mem_ready=1 -> LD_WB.
  - Else, if TIMEOUT_CYC!=0 and wait counter == TIMEOUT_CYC -> FAULT.
  - Else stay and increment the counter.
- mem_ready has priority over timeout when both occur in the same cycle.

LD_WB (4):
- Outputs: pc_addr_sel, ld_sel, reg_wen, wsel_mem.
- Next state: FETCH.

ST_REQ (5):
- Outputs: mem_req, mem_we, pc_en=mem_ready.
- Wait and timeout behaviour identical to LD_REQ.
- On mem_ready -> ST_DONE.

ST_DONE (6):
- Outputs: pc_addr_sel.
- Next state: FETCH.

SPECIAL (15):
- Outputs: mem_we, pc_en. No handshake.
- Next state: ST_DONE.

JMP (7):
- Outputs: pc_addr_sel, jmp_sel, pc_en.
- Next state: JMP_DONE.

JMP_DONE (8):
- Outputs: pc_addr_sel.
- Next state: FETCH.

JAL (12):
- Outputs: as JMP plus reg_wen.
- Next state: JAL_DONE.

JAL_DONE (13):
- Outputs: pc_addr_sel.
- Next state: FETCH.

HALT (9):
- Outputs: pc_addr_sel, pc_en=resume.
- resume=1 -> FETCH (PC advances past the halt). Otherwise stay.

FAULT (14):
- Outputs: fault=1, all others 0 except sw_sel=1.
- Left only via reset.

General rules:
- sw_sel=1 in every state.
- Outputs not listed for a state are 0.
- Wait counter:
  - width = max(1, clog2(TIMEOUT_CYC+1));
  - cleared on entry to LD_REQ or ST_REQ and in every other state;
  - never wraps.
- Reset mid-access (in LD_REQ or ST_REQ) drops mem_req on the next cycle with no write.
- Unused state code: all outputs take their RESET values; next state = RESET.

Optional Feature:
CTRL_INSTR_CNT_EN:
- Defined: adds output instr_count [CNT_W-1:0].
  - Reset value 0.
  - Increments by 1 on every FETCH edge whose opcode is not 1000.
  - Wraps 2^CNT_W-1 -> 0.
  - Does not increment in FAULT, or while held in HALT or LD_REQ/ST_REQ.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset low 2 cycles, then instr=0x0123 -> RESET, FETCH, R_REG, WB, FETCH; pc_en=1 and reg_wen=1 only in R_REG, flag_en=1 in R_REG.
- instr=0x1xxx, mem_ready low 3 cycles then high -> LD_REQ held 4 cycles with mem_req=1; pc_en=1 only on the ready cycle; then LD_WB with reg_wen=1 and wsel_mem=1; then FETCH.
- instr=0x2xxx, TIMEOUT_CYC=15, mem_ready never high -> after 16 cycles in ST_REQ, state=14 and fault=1; stays until reset=0 clears it to state 0.
- instr=0x4000 -> HALT held while resume=0; resume=1 for one cycle -> pc_en=1 that cycle, then FETCH.
- instr=0xCxxx then 0x8000 -> JAL (jmp_sel, pc_en, reg_wen), JAL_DONE, FETCH, then RESET; with CTRL_INSTR_CNT_EN defined, instr_count increments by exactly 1.
- instr=0xFxxx -> SPECIAL with mem_we=1 and pc_en=1, then ST_DONE, then FETCH; mem_req stays 0 throughout.
